// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: launches one aligned load or
// store onto the data bus, waits for d_ack, and returns extended load data.
//
// state | meaning
// IDLE  | no transfer; launch when an aligned, unflushed request is present
// BUS   | d_req held with stable d_* until d_ack
// DONE  | one-cycle completion, done = 1, req_valid ignored
module mem_access_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        d_req,
   output logic        d_we,
   output logic [31:0] d_addr,
   output logic [3:0]  d_be,
   output logic [31:0] d_wdata,
   input  logic        d_ack,
   input  logic [31:0] d_rdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        stallreq,
   output logic        addr_err
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   state_t      state;
   state_t      state_nxt;

   logic [1:0]  size_norm;
   logic        misaligned;
   logic        launch;
   logic        ack_bus;
   logic        kill;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;

   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        uns_q;
   logic        flushed_q;

   logic [7:0]  lane8;
   logic [15:0] lane16;
   logic [31:0] ld_ext;

   // Size code 3 behaves exactly like a word access.
   assign size_norm = (req_size == SZ_BYTE) ? SZ_BYTE :
                      (req_size == SZ_HALF) ? SZ_HALF : SZ_WORD;

   always_comb begin
      misaligned = 1'b0;
      case (size_norm)
         SZ_HALF: misaligned = req_addr[0];
         SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   assign launch   = (state == IDLE) & req_valid & ~misaligned & ~flush;
   assign addr_err = (state == IDLE) & req_valid &  misaligned & ~flush;
   assign stallreq = launch | (state == BUS);
   assign ack_bus  = (state == BUS) & d_ack;
   // A flush seen at any point during BUS, including the ack cycle, cancels reporting.
   assign kill     = flushed_q | flush;

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = req_wdata;
      case (size_norm)
         SZ_BYTE: begin
            wdata_nxt = {4{req_wdata[7:0]}};
            case (req_addr[1:0])
               2'd0:    be_nxt = 4'b1000;
               2'd1:    be_nxt = 4'b0100;
               2'd2:    be_nxt = 4'b0010;
               default: be_nxt = 4'b0001;
            endcase
         end
         SZ_HALF: begin
            wdata_nxt = {2{req_wdata[15:0]}};
            be_nxt    = req_addr[1] ? 4'b0011 : 4'b1100;
         end
         default: begin
            wdata_nxt = req_wdata;
            be_nxt    = 4'b1111;
         end
      endcase
   end

   // Big-endian lane pick: offset 0 is the most significant byte of the word.
   always_comb begin
      lane8  = 8'h00;
      lane16 = 16'h0000;
      ld_ext = d_rdata;
      case (size_q)
         SZ_BYTE: begin
            case (off_q)
               2'd0:    lane8 = d_rdata[31:24];
               2'd1:    lane8 = d_rdata[23:16];
               2'd2:    lane8 = d_rdata[15:8];
               default: lane8 = d_rdata[7:0];
            endcase
            ld_ext = {{24{~uns_q & lane8[7]}}, lane8};
         end
         SZ_HALF: begin
            lane16 = off_q[1] ? d_rdata[15:0] : d_rdata[31:16];
            ld_ext = {{16{~uns_q & lane16[15]}}, lane16};
         end
         default: ld_ext = d_rdata;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = BUS;
         BUS:     if (d_ack) state_nxt = kill ? IDLE : DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         d_req     <= 1'b0;
         d_we      <= 1'b0;
         d_addr    <= 32'h0;
         d_be      <= 4'h0;
         d_wdata   <= 32'h0;
         rdata     <= 32'h0;
         done      <= 1'b0;
         size_q    <= SZ_BYTE;
         off_q     <= 2'd0;
         uns_q     <= 1'b0;
         flushed_q <= 1'b0;
      end else begin
         done <= ack_bus & ~kill;
         if (launch) begin
            d_req     <= 1'b1;
            d_we      <= req_we;
            d_addr    <= {req_addr[31:2], 2'b00};
            d_be      <= be_nxt;
            d_wdata   <= wdata_nxt;
            size_q    <= size_norm;
            off_q     <= req_addr[1:0];
            uns_q     <= req_unsigned;
            flushed_q <= 1'b0;
         end
         if ((state == BUS) && flush) flushed_q <= 1'b1;
         if (ack_bus) begin
            d_req <= 1'b0;
            if (!d_we && !kill) rdata <= ld_ext;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table of single transactions with a
// scoreboard queue, plus hand-written flush, reset and DONE-hold sequences.
module tb_mem_access_ctrl;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_be;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] rdata;
   logic        done;
   logic        stallreq;
   logic        addr_err;

   mem_access_ctrl dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .flush(flush),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .rdata(rdata), .done(done), .stallreq(stallreq), .addr_err(addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] bus_rdata;
      int          ack_dly;
      logic        err;
      logic [3:0]  be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rd;
   } exp_t;

   vec_t        vecs [15];
   exp_t        exp_q [$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] model_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   stall_n;
      set_req(v.we, v.size, v.uns, v.addr, v.wdata);
      d_ack = 1'b0;
      flush = 1'b0;
      #1;
      if (v.err) begin
         chk1("addr_err_set", addr_err, 1'b1);
         chk1("err_stall", stallreq, 1'b0);
         tick();
         req_valid = 1'b0;
         chk1("err_dreq", d_req, 1'b0);
         chk1("err_done", done, 1'b0);
         return;
      end
      chk1("addr_err_clr", addr_err, 1'b0);
      chk1("launch_stall", stallreq, 1'b1);
      e.we   = v.we;
      e.addr = {v.addr[31:2], 2'b00};
      e.be   = v.be;
      e.wd   = v.exp_wd;
      e.rd   = v.we ? model_rd : v.exp_rd;
      if (!v.we) model_rd = v.exp_rd;
      exp_q.push_back(e);
      stall_n = 1;
      tick();
      req_valid = 1'b0;
      for (int n = 1; n <= v.ack_dly; n++) begin
         if (n > 1) tick();
         chk1("bus_dreq", d_req, 1'b1);
         if (stallreq) stall_n++;
         chk("bus_addr", d_addr, exp_q[0].addr);
         chk("bus_be", 32'(d_be), 32'(exp_q[0].be));
         if (n == 1) begin
            chk1("bus_we", d_we, exp_q[0].we);
            if (exp_q[0].we) chk("bus_wdata", d_wdata, exp_q[0].wd);
         end
         if (n == v.ack_dly) begin
            d_ack   = 1'b1;
            d_rdata = v.bus_rdata;
         end
      end
      tick();
      d_ack   = 1'b0;
      d_rdata = $urandom;
      chk1("done_pulse", done, 1'b1);
      chk1("dreq_clr", d_req, 1'b0);
      chk1("done_stall", stallreq, 1'b0);
      e = exp_q.pop_front();
      chk("rdata", rdata, e.rd);
      chk("stall_cycles", 32'(stall_n), 32'(v.ack_dly + 1));
      tick();
      chk1("done_once", done, 1'b0);
   endtask

   initial begin
      //          we    sz    uns   addr          wdata         bus_rdata    dly err  be       exp_wd        exp_rd
      vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,       2, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0,         32'h1122_33F4, 1, 1'b0, 4'b0001, 32'h0, 32'hFFFF_FFF4};
      vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0,         32'h1122_33F4, 2, 1'b0, 4'b0001, 32'h0, 32'h0000_00F4};
      vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0,         32'h1234_8001, 1, 1'b0, 4'b0011, 32'h0, 32'hFFFF_8001};
      vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'h0000_ABCD, 32'h0,       3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
      vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,         32'h0,       1, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D};
      vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0,         32'h8765_4321, 3, 1'b0, 4'b1100, 32'h0, 32'h0000_8765};
      vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0,         32'h8012_3456, 1, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
      vecs[9]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0,         32'h11A2_3344, 2, 1'b0, 4'b0100, 32'h0, 32'hFFFF_FFA2};
      vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h0000_0102, 32'h1234_5678, 32'h0,       1, 1'b0, 4'b0010, 32'h7878_7878, 32'h0};
      vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h0,         32'h0,       1, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h0000_0108, 32'h0,         32'h0102_0304, 2, 1'b0, 4'b1111, 32'h0, 32'h0102_0304};
      vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h0000_010A, 32'h0,         32'h0,       1, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[14] = '{1'b0, 2'd0, 1'b1, 32'h0000_0202, 32'h0,         32'h0000_9900, 1, 1'b0, 4'b0010, 32'h0, 32'h0000_0099};

      resetn = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
      d_ack = 1'b0; d_rdata = 32'h0;
      model_rd = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_dreq", d_req, 1'b0);
      chk1("rst_dwe", d_we, 1'b0);
      chk("rst_daddr", d_addr, 32'h0);
      chk("rst_dbe", 32'(d_be), 32'h0);
      chk("rst_dwdata", d_wdata, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_stall", stallreq, 1'b0);
      chk1("rst_addr_err", addr_err, 1'b0);
      resetn = 1'b1;
      tick();

      for (int i = 0; i < 15; i++) run_vec(vecs[i]);

      // Flush mid-BUS, ack three cycles later.
      set_req(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
      #1;
      chk1("fl_launch_stall", stallreq, 1'b1);
      tick();
      req_valid = 1'b0;
      chk1("fl_dreq1", d_req, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int n = 2; n <= 4; n++) begin
         chk1("fl_dreq_held", d_req, 1'b1);
         chk1("fl_stall_held", stallreq, 1'b1);
         chk("fl_addr_held", d_addr, 32'h0000_0300);
         if (n == 4) begin
            d_ack = 1'b1;
            d_rdata = 32'h55AA_55AA;
         end else tick();
      end
      tick();
      d_ack = 1'b0;
      chk1("fl_no_done", done, 1'b0);
      chk1("fl_dreq_clr", d_req, 1'b0);
      chk1("fl_stall_clr", stallreq, 1'b0);
      chk("fl_rdata_kept", rdata, model_rd);
      set_req(1'b0, 2'd2, 1'b0, 32'h0000_0302, 32'h0);
      #1;
      chk1("fl_idle_err", addr_err, 1'b1);
      req_valid = 1'b0;
      tick();
      chk1("fl_no_done2", done, 1'b0);

      // Flush coincident with d_ack.
      set_req(1'b0, 2'd2, 1'b0, 32'h0000_0304, 32'h0);
      tick();
      req_valid = 1'b0;
      chk1("fa_dreq", d_req, 1'b1);
      tick();
      d_ack = 1'b1;
      flush = 1'b1;
      d_rdata = 32'h7777_7777;
      tick();
      d_ack = 1'b0;
      flush = 1'b0;
      chk1("fa_no_done", done, 1'b0);
      chk1("fa_dreq_clr", d_req, 1'b0);
      chk("fa_rdata_kept", rdata, model_rd);
      tick();
      chk1("fa_no_done2", done, 1'b0);

      // Flush at the request cycle suppresses launch and addr_err.
      set_req(1'b0, 2'd2, 1'b0, 32'h0000_0308, 32'h0);
      flush = 1'b1;
      #1;
      chk1("fr_stall", stallreq, 1'b0);
      req_addr = 32'h0000_0309;
      #1;
      chk1("fr_addr_err", addr_err, 1'b0);
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
      chk1("fr_no_dreq", d_req, 1'b0);

      // req_valid held through BUS and DONE must not relaunch.
      set_req(1'b0, 2'd0, 1'b1, 32'h0000_0400, 32'h0);
      tick();
      chk1("hv_dreq", d_req, 1'b1);
      d_ack = 1'b1;
      d_rdata = 32'hA500_0000;
      tick();
      d_ack = 1'b0;
      chk1("hv_done", done, 1'b1);
      chk1("hv_done_stall", stallreq, 1'b0);
      chk("hv_rdata", rdata, 32'h0000_00A5);
      model_rd = 32'h0000_00A5;
      tick();
      chk1("hv_no_relaunch", d_req, 1'b0);
      chk1("hv_done_once", done, 1'b0);
      req_valid = 1'b0;

      // Reset during BUS, then a late ack.
      set_req(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
      tick();
      req_valid = 1'b0;
      chk1("rb_dreq", d_req, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk1("rb_dreq_drop", d_req, 1'b0);
      chk1("rb_stall", stallreq, 1'b0);
      chk("rb_rdata", rdata, 32'h0);
      model_rd = 32'h0;
      tick();
      resetn = 1'b1;
      d_ack = 1'b1;
      d_rdata = 32'h1234_5678;
      tick();
      d_ack = 1'b0;
      chk1("rb_late_done", done, 1'b0);
      chk1("rb_late_dreq", d_req, 1'b0);
      tick();
      chk1("rb_late_done2", done, 1'b0);
      chk("rb_rdata2", rdata, model_rd);

      chk("sb_empty", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
